// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   NOP_INSTR        : value loaded into IF/ID on a bubble or flush
//   fetch_state_t    : fetch FSM encoding (FETCH / DRAIN)
//   DEFAULT_RESET_PC : default first fetch address after reset
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,   // request outstanding at pc
        DRAIN = 1'b1    // stale request outstanding, its data is thrown away
    } fetch_state_t;

    // Redirect targets are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   clear : synchronous clear (highest priority)
//   inc   : add one this cycle unless already all-ones
//   count : current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction memory request
// interface, IF/ID pipeline register and a stall counter.
//   clk, rst_n                  : clock, synchronous active-low reset
//   pc_write, if_id_write       : hazard unit holds (0 = hold)
//   branch_taken/branch_target  : taken branch resolved in ID
//   jump/jump_target            : jump decoded in ID
//   imem_req/imem_addr          : fetch request, address stable until ready
//   imem_ready/imem_rdata       : fetch completion and data
//   if_id_instr/pc4/valid       : IF/ID register contents
//   stall_count                 : saturating count of pc_write==0 cycles
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_count
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  pending, pending_nxt;
    logic [31:0]  instr_nxt, pc4_nxt;
    logic         valid_nxt;

    logic         redirect, accept;
    logic [31:0]  target, pc_plus4;

    assign redirect = pc_write & (branch_taken | jump);
    assign target   = word_align(branch_taken ? branch_target : jump_target);
    assign pc_plus4 = pc + 32'd4;
    assign accept   = (state == FETCH) & imem_ready & pc_write & if_id_write & ~redirect;

    // While draining, pc still holds the stale address, so the request
    // stays stable without a separate address register.
    assign imem_req  = 1'b1;
    assign imem_addr = pc;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pending_nxt = pending;
        instr_nxt   = if_id_instr;
        pc4_nxt     = if_id_pc4;
        valid_nxt   = if_id_valid;

        if (redirect) begin
            // Flush regardless of if_id_write: the instruction behind a
            // redirect is on the wrong path.
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
            if (imem_ready) begin
                pc_nxt    = target;
                state_nxt = FETCH;
            end else begin
                pending_nxt = target;
                state_nxt   = DRAIN;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        pc_nxt    = pc_plus4;
                        instr_nxt = imem_rdata;
                        pc4_nxt   = pc_plus4;
                        valid_nxt = 1'b1;
                    end else if (if_id_write) begin
                        instr_nxt = NOP_INSTR;
                        valid_nxt = 1'b0;
                    end
                end
                DRAIN: begin
                    if (if_id_write) begin
                        instr_nxt = NOP_INSTR;
                        valid_nxt = 1'b0;
                    end
                    // A PC hold keeps re-requesting the stale address;
                    // its data is still discarded.
                    if (imem_ready && pc_write) begin
                        pc_nxt    = pending;
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pending     <= 32'h0;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pending     <= pending_nxt;
            if_id_instr <= instr_nxt;
            if_id_pc4   <= pc4_nxt;
            if_id_valid <= valid_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (~rst_n),
        .inc   (~pc_write),
        .count (stall_count)
    );

endmodule
